// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared RV32I opcode constants and datapath select encodings
package rv32_ctrl_pkg;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic PC_NEXT_PC4  = 1'b0;
   localparam logic PC_ALU_PC    = 1'b0;
   localparam logic ADDR_SEL_ALU = 1'b0;
   localparam logic ALU_ADD      = 1'b0;
   function automatic logic [31:0] u_imm(input logic [31:0] insn);
      return {insn[31:12], 12'h000};
   endfunction
endpackage

// File: rtl/decoder_uinsn_auipc.sv
// decoder_uinsn_auipc: control decoder slice for the AUIPC instruction
module decoder_uinsn_auipc
   import rv32_ctrl_pkg::*;
#(
   parameter logic [6:0] OPCODE = OPCODE_AUIPC
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] INSN,
   output logic        sub_sra,
   output logic        addr_sel,
   output logic        pc_next_sel,
   output logic        pc_alu_sel,
   output logic        rd_clk,
   output logic        mem_clk,
   output logic        is_auipc,
   output logic [4:0]  rd_addr,
   output logic [31:0] imm_u
);
   // Case-equality keeps X/Z opcode bits from ever matching.
   always_comb begin
      is_auipc    = (INSN[6:0] === OPCODE);
      sub_sra     = ALU_ADD;
      addr_sel    = ADDR_SEL_ALU;
      pc_next_sel = PC_NEXT_PC4;
      pc_alu_sel  = PC_ALU_PC;
      mem_clk     = 1'b0;
      rd_clk      = CLK & is_auipc & RST_N;
   end
   // Capture rd and the U-immediate for the datapath; reset wins over load.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_addr <= 5'd0;
         imm_u   <= 32'd0;
      end else if (is_auipc) begin
         rd_addr <= INSN[11:7];
         imm_u   <= u_imm(INSN);
      end
   end
endmodule

// File: tb/tb_decoder_uinsn_auipc.sv
// tb_decoder_uinsn_auipc: randomized scoreboard bench for the AUIPC decoder slice
module tb_decoder_uinsn_auipc;
   localparam int HALF_PERIOD = 5;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        gate;
   } exp_t;
   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] INSN;
   logic        sub_sra, addr_sel, pc_next_sel, pc_alu_sel, rd_clk, mem_clk, is_auipc;
   logic [4:0]  rd_addr;
   logic [31:0] imm_u;
   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] m_imm = 32'd0;

   decoder_uinsn_auipc dut (
      .CLK(CLK), .RST_N(RST_N), .INSN(INSN),
      .sub_sra(sub_sra), .addr_sel(addr_sel), .pc_next_sel(pc_next_sel),
      .pc_alu_sel(pc_alu_sel), .rd_clk(rd_clk), .mem_clk(mem_clk),
      .is_auipc(is_auipc), .rd_addr(rd_addr), .imm_u(imm_u)
   );

   always #HALF_PERIOD CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic apply(input logic [31:0] insn, input logic rst_n);
      logic op;
      exp_t e;
      op = (insn[6:0] === 7'b0010111);
      INSN = insn;
      RST_N = rst_n;
      n_vec++;
      if (!rst_n) begin
         m_rd = 5'd0;
         m_imm = 32'd0;
      end else if (op) begin
         m_rd = insn[11:7];
         m_imm = insn & 32'hFFFF_F000;
      end
      e.rd = m_rd;
      e.imm = m_imm;
      e.gate = op & rst_n;
      sb.push_back(e);
      #1;
      chk("is_auipc_lo", {31'd0, is_auipc}, {31'd0, op});
      chk("rd_clk_lo", {31'd0, rd_clk}, 32'd0);
      chk("mem_clk_lo", {31'd0, mem_clk}, 32'd0);
      chk("selects_lo", {28'd0, sub_sra, addr_sel, pc_next_sel, pc_alu_sel}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Monitor: every rising edge the DUT presents registered results.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
         end else begin
            e = sb.pop_front();
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
            chk("imm_u", imm_u, e.imm);
            chk("imm_u_low", {20'd0, imm_u[11:0]}, 32'd0);
            chk("rd_clk_hi", {31'd0, rd_clk}, {31'd0, e.gate});
            chk("mem_clk_hi", {31'd0, mem_clk}, 32'd0);
            chk("selects_hi", {28'd0, sub_sra, addr_sel, pc_next_sel, pc_alu_sel}, 32'd0);
         end
      end
   end

   initial begin
      logic [31:0] w;
      apply(32'h0000_0013, 1'b0);
      apply(32'h1234_5117, 1'b1);
      apply(32'h1234_5137, 1'b1);
      apply(32'hFFFF_F097, 1'b0);
      apply(32'hFFFF_F097, 1'b1);
      w = 32'hABCD_E397;
      w[6] = 1'bx;
      apply(w, 1'b1);
      w[6] = 1'bz;
      apply(w, 1'b1);
      apply(32'h0000_0017, 1'b1);
      for (int i = 0; i < 100; i++)
         apply({$urandom() & 32'hFFFF_FF80} | 32'h17, 1'b1);
      for (int i = 0; i < 80; i++) begin
         w = $urandom();
         if ($urandom_range(1, 0) == 1) w[6:0] = 7'b0010111;
         apply(w, $urandom_range(9, 0) != 0);
      end
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decoder_uinsn_auipc.md
Name: decoder_uinsn_auipc

Overview:
Control decoder slice for the U-type AUIPC instruction (opcode 7'b0010111) in the single-cycle RV32I control unit. It drives the datapath select lines, gates the register-file write clock, and keeps memory writes inhibited. It also extracts rd and the U-immediate into registered outputs for the datapath. A simulation-only clock generator, clock_gen, supplies CLK in benches.

Parameters:
OPCODE_AUIPC, 7'b0010111, opcode this slice recognises.

Ports:
CLK  input  1  system clock; rising-edge active.
RST_N  input  1  synchronous reset, active-low.
INSN  input  32  current instruction word.
sub_sra  output  1  ALU sub/sra modifier; 0 = add.
addr_sel  output  1  memory address source select.
pc_next_sel  output  1  next-PC select; 0 = PC+4.
pc_alu_sel  output  1  ALU operand-A select; 0 = PC path for AUIPC.
rd_clk  output  1  register-file write clock (gated CLK).
mem_clk  output  1  data-memory write clock.
is_auipc  output  1  INSN[6:0] == OPCODE_AUIPC; combinational.
rd_addr  output  5  registered INSN[11:7].
imm_u  output  32  registered {INSN[31:12], 12'b0}.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST_N. Sampled only on the CLK rising edge.
- Select lines: sub_sra, addr_sel, pc_next_sel and pc_alu_sel are constant 0, independent of INSN, CLK and RST_N.
- mem_clk: constant 0. AUIPC never writes memory.
- is_auipc: purely combinational compare of INSN[6:0].
- rd_clk: equals CLK & is_auipc & RST_N, with no added delay or registering.
  - Follows CLK level while an AUIPC is presented and reset is deasserted.
  - Held at 0 for any other opcode, or while RST_N = 0.
- rd_addr and imm_u:
  - Load INSN[11:7] and {INSN[31:12], 12'h000} on every rising edge with RST_N = 1 and is_auipc = 1.
  - Hold their value when is_auipc = 0.
  - Clear to 0 on a rising edge with RST_N = 0. Reset has priority over load.
- Reset values: rd_addr = 0, imm_u = 0. All other outputs are combinational and follow their defining equations.
- Latency: registered outputs update one edge after INSN is applied. Control lines are 0-latency.
- Boundary cases:
  - INSN with rd = 0 still gates rd_clk; the register file ignores writes to x0.
  - imm_u low 12 bits are always zero.
  - An X or Z on INSN[6:0] gives is_auipc = 0 (case-equality compare).

Decomposition:
- Shared package rv32_ctrl_pkg: opcode constants (OPCODE_AUIPC, OPCODE_LUI, …) and the select-line encodings (PC_NEXT_PC4 = 0, PC_ALU_PC = 0, ADDR_SEL_ALU = 0).
- Sub-module clock_gen, simulation-only, not synthesised:
  - Parameter HALF_PERIOD, default 5 ns.
  - Output CLK; starts at 0 and toggles every HALF_PERIOD.
- The decoder itself has no sub-modules.

Test Plan:
1. INSN = 32'h12345117, RST_N = 1, sample at #10 -> sub_sra = 0, addr_sel = 0, pc_next_sel = 0, pc_alu_sel = 0, mem_clk = 0, rd_clk === CLK, is_auipc = 1.
2. Same INSN, one rising edge with RST_N = 1 -> rd_addr = 5'd2, imm_u = 32'h12345000.
3. INSN = 32'h12345137 (LUI opcode) -> is_auipc = 0, rd_clk = 0 on both CLK levels; rd_addr and imm_u hold their previous values.
4. RST_N = 0 for one edge with INSN = 32'hFFFFF097 -> rd_addr = 0, imm_u = 0, rd_clk = 0. Next edge with RST_N = 1 -> rd_addr = 1, imm_u = 32'hFFFFF000.
5. Sweep INSN[31:7] randomly with AUIPC opcode over 100 cycles -> all four select lines and mem_clk remain 0; imm_u[11:0] = 0 every cycle.
